banco_registradores_param: RTL

Parametrised register file for the ID stage, replacing the discrete single-word registers.
- Two combinational read ports and one synchronous write port.
- Optional hardwired-zero entry 0 and optional write-to-read bypass.
- Per-entry pending (scoreboard) bits: set when a producer instruction issues, cleared on writeback, used by hazard detection to stall dependent reads.

---
 rtl/banco_registradores_param_pkg.sv | 9 +
 rtl/banco_registradores_param_if.sv | 38 +++
 rtl/banco_registradores_param_tabela_pendencias.sv | 45 ++++
 rtl/banco_registradores_param.sv | 79 +++++++
 4 files changed

// File: rtl/banco_registradores_param_pkg.sv
// Shared sizing for the ID-stage register file, decode and hazard unit.
// Holds default widths and the index of the hardwired-zero entry.
package banco_registradores_param_pkg;

    localparam int LARGURA_PADRAO  = 32;
    localparam int NUM_REGS_PADRAO = 32;
    localparam int ENDERECO_ZERO   = 0;

endpackage

// File: rtl/banco_registradores_param_if.sv
// Register-file access bundle: two read ports with hazard flags, writeback, issue reservation, flush.
// The master is the ID/WB side; the slave is the register file.
interface banco_registradores_param_if
    import banco_registradores_param_pkg::*;
#(
    parameter int LARGURA  = LARGURA_PADRAO,
    parameter int NUM_REGS = NUM_REGS_PADRAO,
    parameter int LARG_END = $clog2(NUM_REGS)
);

    logic [LARG_END-1:0] end_leitura1;
    logic [LARG_END-1:0] end_leitura2;
    logic [LARGURA-1:0]  dado_leitura1;
    logic [LARGURA-1:0]  dado_leitura2;
    logic                pendente1;
    logic                pendente2;
    logic                habilita_escrita;
    logic [LARG_END-1:0] end_escrita;
    logic [LARGURA-1:0]  dado_escrita;
    logic                reserva_valida;
    logic [LARG_END-1:0] end_reserva;
    logic                limpa_reservas;

    modport master (
        output end_leitura1, end_leitura2,
        input  dado_leitura1, dado_leitura2, pendente1, pendente2,
        output habilita_escrita, end_escrita, dado_escrita,
        output reserva_valida, end_reserva, limpa_reservas
    );

    modport slave (
        input  end_leitura1, end_leitura2,
        output dado_leitura1, dado_leitura2, pendente1, pendente2,
        input  habilita_escrita, end_escrita, dado_escrita,
        input  reserva_valida, end_reserva, limpa_reservas
    );

endinterface

// File: rtl/banco_registradores_param_tabela_pendencias.sv
// Per-entry pending bits: set on issue, cleared on writeback, cleared en masse on flush.
// Lookups are combinational; updates land on the next clock edge; no backpressure.
module banco_registradores_param_tabela_pendencias #(
    parameter int NUM_REGS = 32,
    parameter int LARG_END = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reserva_valida,
    input  logic [LARG_END-1:0] end_reserva,
    input  logic                limpa_reservas,
    input  logic                escrita_valida,
    input  logic [LARG_END-1:0] end_escrita,
    input  logic [LARG_END-1:0] end_consulta1,
    input  logic [LARG_END-1:0] end_consulta2,
    output logic                pendente_consulta1,
    output logic                pendente_consulta2
);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_prox;
    logic                reserva_ok;

    assign reserva_ok = reserva_valida && !((ZERO_REG != 0) && (end_reserva == '0));

    // Set is applied after clear so a newer producer wins over an older writeback.
    always_comb begin
        pend_prox = pend;
        if (escrita_valida) pend_prox[end_escrita] = 1'b0;
        if (reserva_ok)     pend_prox[end_reserva] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || limpa_reservas) begin
            pend <= '0;
        end else begin
            pend <= pend_prox;
        end
    end

    assign pendente_consulta1 = pend[end_consulta1];
    assign pendente_consulta2 = pend[end_consulta2];

endmodule

// File: rtl/banco_registradores_param.sv
// ID-stage register file: two combinational read ports, one write port, optional zero entry and bypass.
// Reads are 0-cycle, writes land on the next edge; no backpressure, pending flags drive the hazard stall.
module banco_registradores_param
    import banco_registradores_param_pkg::*;
#(
    parameter int LARGURA  = LARGURA_PADRAO,
    parameter int NUM_REGS = NUM_REGS_PADRAO,
    parameter int LARG_END = $clog2(NUM_REGS),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    banco_registradores_param_if.slave   bus
);

    localparam logic [LARG_END-1:0] END_ZERO = LARG_END'(ENDERECO_ZERO);

    logic [LARGURA-1:0] regs [NUM_REGS];
    logic               escrita_ok;
    logic               acerto1;
    logic               acerto2;
    logic               zero1;
    logic               zero2;
    logic               pend_tab1;
    logic               pend_tab2;

    // A write to the hardwired-zero entry is dropped everywhere, including bypass and pending clear.
    assign escrita_ok = bus.habilita_escrita &&
                        !((ZERO_REG != 0) && (bus.end_escrita == END_ZERO));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (escrita_ok) begin
            regs[bus.end_escrita] <= bus.dado_escrita;
        end
    end

    assign acerto1 = (BYPASS != 0) && escrita_ok && (bus.end_escrita == bus.end_leitura1);
    assign acerto2 = (BYPASS != 0) && escrita_ok && (bus.end_escrita == bus.end_leitura2);
    assign zero1   = (ZERO_REG != 0) && (bus.end_leitura1 == END_ZERO);
    assign zero2   = (ZERO_REG != 0) && (bus.end_leitura2 == END_ZERO);

    always_comb begin
        bus.dado_leitura1 = regs[bus.end_leitura1];
        if (zero1)        bus.dado_leitura1 = '0;
        else if (acerto1) bus.dado_leitura1 = bus.dado_escrita;

        bus.dado_leitura2 = regs[bus.end_leitura2];
        if (zero2)        bus.dado_leitura2 = '0;
        else if (acerto2) bus.dado_leitura2 = bus.dado_escrita;
    end

    // A writeback arriving this cycle resolves the hazard immediately when bypassing.
    assign bus.pendente1 = pend_tab1 && !acerto1 && !zero1;
    assign bus.pendente2 = pend_tab2 && !acerto2 && !zero2;

    banco_registradores_param_tabela_pendencias #(
        .NUM_REGS (NUM_REGS),
        .LARG_END (LARG_END),
        .ZERO_REG (ZERO_REG)
    ) u_tabela_pendencias (
        .clk                (clk),
        .reset              (reset),
        .reserva_valida     (bus.reserva_valida),
        .end_reserva        (bus.end_reserva),
        .limpa_reservas     (bus.limpa_reservas),
        .escrita_valida     (escrita_ok),
        .end_escrita        (bus.end_escrita),
        .end_consulta1      (bus.end_leitura1),
        .end_consulta2      (bus.end_leitura2),
        .pendente_consulta1 (pend_tab1),
        .pendente_consulta2 (pend_tab2)
    );

endmodule
